// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the five-digit decimal entry converter.
package decimal_entry_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned ACC_WIDTH  = 17;
  localparam logic [ACC_WIDTH-1:0] MAX_VALUE = 17'd65535;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } entry_state_t;

  // acc*10 + d built from shifts; 99999 fits in ACC_WIDTH so nothing wraps.
  function automatic logic [ACC_WIDTH-1:0] mul10_add(input logic [ACC_WIDTH-1:0] acc,
                                                      input bcd_digit_t d);
    return (acc << 3) + (acc << 1) + {{(ACC_WIDTH-4){1'b0}}, d};
  endfunction

endpackage

// File: rtl/decimal_entry_converter_key_edge_detect.sv
// Push-button conditioning: SYNC_STAGES synchroniser flops, one history flop,
// single-cycle pulse per 0->1 transition of the synchronised level.
module key_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic nReset,
  input  logic KeyLevel,
  output logic KeyEdge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], KeyLevel};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign KeyEdge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/decimal_entry_converter.sv
// Five-digit BCD entry from buttons/switches, converted to 16-bit binary by a
// five-step multiply-by-10 sequence on Enter.
module decimal_entry_converter
  import decimal_entry_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        SATURATE    = 1'b1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [3:0]  DigitIn,
  input  logic        DigitStrobe,
  input  logic        Backspace,
  input  logic        Clear,
  input  logic        Enter,
  output logic        Busy,
  output logic [15:0] ValueOut,
  output logic        ValueValid,
  output logic        Overflow,
  output logic [19:0] DigitsOut,
  output logic [2:0]  DigitCount
);

  logic digit_edge, back_edge, clear_edge, enter_edge;

  key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_digit (
    .Clock(Clock), .nReset(nReset), .KeyLevel(DigitStrobe), .KeyEdge(digit_edge)
  );
  key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_back (
    .Clock(Clock), .nReset(nReset), .KeyLevel(Backspace), .KeyEdge(back_edge)
  );
  key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .Clock(Clock), .nReset(nReset), .KeyLevel(Clear), .KeyEdge(clear_edge)
  );
  key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
    .Clock(Clock), .nReset(nReset), .KeyLevel(Enter), .KeyEdge(enter_edge)
  );

  entry_state_t         state_q;
  logic [2:0]           idx_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [19:0]          digits_q;
  logic [2:0]           count_q;
  logic [15:0]          value_q;
  logic                 valid_q;
  logic                 ovf_q;
  bcd_digit_t           cur_digit;

  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) cur_digit = digits_q[4*i +: 4];
    end
    acc_next = mul10_add(acc_q, cur_digit);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      digits_q <= '0;
      count_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clear_edge) begin
            digits_q <= '0;
            count_q  <= '0;
            value_q  <= '0;
            ovf_q    <= 1'b0;
          end else if (enter_edge) begin
            acc_q   <= '0;
            idx_q   <= 3'(NUM_DIGITS - 1);
            state_q <= CONVERT;
          end else if (back_edge) begin
            if (count_q != 3'd0) begin
              digits_q <= {4'd0, digits_q[19:4]};
              count_q  <= count_q - 3'd1;
            end
          end else if (digit_edge) begin
            if (DigitIn <= 4'd9 && count_q < 3'(NUM_DIGITS)) begin
              digits_q <= {digits_q[15:0], DigitIn};
              count_q  <= count_q + 3'd1;
            end
          end
        end
        CONVERT: begin
          acc_q <= acc_next;
          // Results are registered on the final step so they are visible
          // throughout the single DONE cycle, together with the valid pulse.
          if (idx_q == 3'd0) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            ovf_q   <= (acc_next > MAX_VALUE);
            if (acc_next > MAX_VALUE) value_q <= SATURATE ? 16'hFFFF : acc_next[15:0];
            else                      value_q <= acc_next[15:0];
          end else begin
            idx_q <= idx_q - 3'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy       = (state_q != IDLE);
  assign ValueOut   = value_q;
  assign ValueValid = valid_q;
  assign Overflow   = ovf_q;
  assign DigitsOut  = digits_q;
  assign DigitCount = count_q;

endmodule
